// File: rtl/pipeline_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_monitor
//  Description : Cycle/instruction counter and halt-loop detector (period 1-4)
//                for the 5-stage datapath debug outputs. Optional cycle
//                timeout enabled by defining PIPE_MON_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_monitor #(
    parameter int          CNT_W          = 32,
    parameter int          THR1           = 3,
    parameter int          THR2           = 4,
    parameter int          THR3           = 6,
    parameter int          THR4           = 8,
    parameter logic [31:0] NOP_INSTR      = 32'h00000013,
    parameter int          TIMEOUT_CYCLES = 2000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [31:0]      pc,
    input  logic [31:0]      instr,
    input  logic             stall,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count,
    output logic             halted,
    output logic [2:0]       loop_len,
    output logic [31:0]      halt_pc,
    output logic             timeout
);

    localparam logic [0:0] c_ST_RUN  = 1'b0;
    localparam logic [0:0] c_ST_HALT = 1'b1;
    localparam int         c_MC_W    = 8;
    localparam logic [c_MC_W-1:0] c_THR [4] = '{c_MC_W'(THR1), c_MC_W'(THR2),
                                                c_MC_W'(THR3), c_MC_W'(THR4)};
    localparam logic [CNT_W-1:0]  c_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  c_TO_LIM = CNT_W'(TIMEOUT_CYCLES);
`ifdef PIPE_MON_TIMEOUT_EN
    localparam logic c_TO_EN = 1'b1;
`else
    localparam logic c_TO_EN = 1'b0;
`endif

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_cyc;
    logic [CNT_W-1:0]  r_icnt;
    logic              r_halted;
    logic [2:0]        r_len;
    logic [31:0]       r_halt_pc;
    logic              r_timeout;
    logic [31:0]       r_hist [4];
    logic [31:0]       r_prev_instr;
    logic [2:0]        r_hv;
    logic [c_MC_W-1:0] r_mc [4];

    logic [CNT_W-1:0]  w_cyc_nxt;
    logic [CNT_W-1:0]  w_icnt_nxt;
    logic [3:0]        w_match;
    logic [3:0]        w_hit;
    logic [c_MC_W-1:0] w_mc_nxt [4];
    logic [2:0]        w_len;
    logic              w_det;
    logic              w_to_hit;

    assign w_cyc_nxt  = (&r_cyc) ? r_cyc : r_cyc + c_ONE;
    assign w_icnt_nxt = (!stall && (instr != NOP_INSTR) && !(&r_icnt)) ? r_icnt + c_ONE : r_icnt;

    // r_hist[k] holds the PC seen k+1 non-stall edges ago
    generate
        for (genvar k = 0; k < 4; k++) begin : g_match
            if (k == 0) begin : g_self
                assign w_match[k] = (r_hv > 3'(k)) && (pc == r_hist[k]) && (instr == r_prev_instr);
            end else begin : g_hist
                assign w_match[k] = (r_hv > 3'(k)) && (pc == r_hist[k]);
            end
            assign w_mc_nxt[k] = w_match[k] ? r_mc[k] + c_MC_W'(1) : '0;
            assign w_hit[k]    = !stall && (w_mc_nxt[k] == c_THR[k]);
        end
    endgenerate

    always_comb begin
        w_len = 3'd0;
        for (int k = 3; k >= 0; k--) begin
            if (w_hit[k]) w_len = 3'(k + 1);
        end
    end

    assign w_det    = |w_hit;
    assign w_to_hit = c_TO_EN && (w_cyc_nxt == c_TO_LIM);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_ST_RUN;
            r_cyc        <= '0;
            r_icnt       <= '0;
            r_halted     <= 1'b0;
            r_len        <= 3'd0;
            r_halt_pc    <= 32'd0;
            r_timeout    <= 1'b0;
            r_prev_instr <= 32'd0;
            r_hv         <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                r_hist[i] <= 32'd0;
                r_mc[i]   <= '0;
            end
        end else if (clear) begin
            r_state      <= c_ST_RUN;
            r_cyc        <= '0;
            r_icnt       <= '0;
            r_halted     <= 1'b0;
            r_len        <= 3'd0;
            r_halt_pc    <= 32'd0;
            r_timeout    <= 1'b0;
            r_prev_instr <= 32'd0;
            r_hv         <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                r_hist[i] <= 32'd0;
                r_mc[i]   <= '0;
            end
        end else if (r_state == c_ST_RUN) begin
            r_cyc  <= w_cyc_nxt;
            r_icnt <= w_icnt_nxt;
            // Stall edges freeze history so a bubble never looks like a loop
            if (!stall) begin
                r_hist[0] <= pc;
                for (int i = 1; i < 4; i++) r_hist[i] <= r_hist[i-1];
                r_prev_instr <= instr;
                if (r_hv != 3'd4) r_hv <= r_hv + 3'd1;
                for (int i = 0; i < 4; i++) r_mc[i] <= w_mc_nxt[i];
            end
            if (w_det) begin
                r_state   <= c_ST_HALT;
                r_halted  <= 1'b1;
                r_len     <= w_len;
                r_halt_pc <= pc;
            end else if (w_to_hit) begin
                r_state   <= c_ST_HALT;
                r_halted  <= 1'b1;
                r_timeout <= 1'b1;
                r_len     <= 3'd0;
                r_halt_pc <= pc;
            end
        end
    end

    assign cycle_count = r_cyc;
    assign instr_count = r_icnt;
    assign halted      = r_halted;
    assign loop_len    = r_len;
    assign halt_pc     = r_halt_pc;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_monitor
//  Description : Directed self-checking bench for pipeline_monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_monitor;

    logic        clock;
    logic        reset_n;
    logic        clear;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        stall;

    logic [31:0] cyc, icnt, hpc;
    logic        hlt, tmo;
    logic [2:0]  len;

    logic [3:0]  s_cyc, s_icnt;
    logic [31:0] s_hpc;
    logic        s_hlt, s_tmo;
    logic [2:0]  s_len;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_monitor u_dut (
        .clock(clock), .reset_n(reset_n), .clear(clear), .pc(pc), .instr(instr), .stall(stall),
        .cycle_count(cyc), .instr_count(icnt), .halted(hlt), .loop_len(len),
        .halt_pc(hpc), .timeout(tmo)
    );

    pipeline_monitor #(.CNT_W(4)) u_sat (
        .clock(clock), .reset_n(reset_n), .clear(clear), .pc(pc), .instr(instr), .stall(stall),
        .cycle_count(s_cyc), .instr_count(s_icnt), .halted(s_hlt), .loop_len(s_len),
        .halt_pc(s_hpc), .timeout(s_tmo)
    );

`ifdef PIPE_MON_TIMEOUT_EN
    logic [31:0] t_cyc, t_icnt, t_hpc;
    logic        t_hlt, t_tmo;
    logic [2:0]  t_len;

    pipeline_monitor #(.TIMEOUT_CYCLES(20)) u_to (
        .clock(clock), .reset_n(reset_n), .clear(clear), .pc(pc), .instr(instr), .stall(stall),
        .cycle_count(t_cyc), .instr_count(t_icnt), .halted(t_hlt), .loop_len(t_len),
        .halt_pc(t_hpc), .timeout(t_tmo)
    );
`endif

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step(input logic [31:0] p, input logic [31:0] i, input logic s);
        pc    = p;
        instr = i;
        stall = s;
        tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        clear   = 1'b0;
        pc      = 32'd0;
        instr   = 32'd0;
        stall   = 1'b0;
        #2;
        check("rst_cycle", cyc, 0);
        check("rst_instr", icnt, 0);
        check("rst_halted", {31'd0, hlt}, 0);
        check("rst_len", {29'd0, len}, 0);
        check("rst_hpc", hpc, 0);
        check("rst_timeout", {31'd0, tmo}, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Period-1 loop
        for (int i = 0; i < 3; i++) step(32'h28, 32'h6F, 1'b0);
        check("p1_early", {31'd0, hlt}, 0);
        step(32'h28, 32'h6F, 1'b0);
        check("p1_halted", {31'd0, hlt}, 1);
        check("p1_len", {29'd0, len}, 1);
        check("p1_hpc", hpc, 32'h28);
        check("p1_cycle", cyc, 4);
        check("p1_instr", icnt, 4);
        for (int i = 0; i < 3; i++) step(32'h200 + 32'(4 * i), 32'h33, 1'b0);
        check("hold_cycle", cyc, 4);
        check("hold_hpc", hpc, 32'h28);
        check("hold_len", {29'd0, len}, 1);

        // Clear while halted, then period-2 loop
        pulse_clear();
        check("clr_cycle", cyc, 0);
        check("clr_instr", icnt, 0);
        check("clr_halted", {31'd0, hlt}, 0);
        check("clr_len", {29'd0, len}, 0);
        check("clr_hpc", hpc, 0);
        for (int i = 0; i < 6; i++) begin
            step((i % 2) ? 32'h44 : 32'h40, (i % 2) ? 32'h6F : 32'h13, 1'b0);
            if (i == 4) check("p2_early", {31'd0, hlt}, 0);
        end
        check("p2_halted", {31'd0, hlt}, 1);
        check("p2_len", {29'd0, len}, 2);
        check("p2_hpc", hpc, 32'h44);
        check("p2_cycle", cyc, 6);
        check("p2_instr", icnt, 3);

        // Stall immunity
        pulse_clear();
        for (int i = 0; i < 4; i++) step(32'(4 * i), 32'h33, 1'b0);
        check("pre_stall_instr", icnt, 4);
        for (int i = 0; i < 10; i++) step(32'h10, 32'h33, 1'b1);
        check("stall_halted", {31'd0, hlt}, 0);
        check("stall_cycle", cyc, 14);
        check("stall_instr", icnt, 4);

        // Period-4 loop with a stall burst in the middle
        for (int i = 0; i < 12; i++) begin
            step(32'h20 + 32'(4 * (i % 4)), 32'h33, 1'b0);
            if (i == 5) for (int j = 0; j < 3; j++) step(32'h2C, 32'h33, 1'b1);
            if (i == 10) check("p4_early", {31'd0, hlt}, 0);
        end
        check("p4_halted", {31'd0, hlt}, 1);
        check("p4_len", {29'd0, len}, 4);
        check("p4_hpc", hpc, 32'h2C);
        check("p4_cycle", cyc, 29);
        check("p4_instr", icnt, 16);

        // Non-repeating run: saturation and timeout
        pulse_clear();
        for (int i = 0; i < 20; i++) step(32'h100 + 32'(4 * i), 32'h33, 1'b0);
        check("nr_cycle", cyc, 20);
        check("nr_halted", {31'd0, hlt}, 0);
        check("nr_timeout", {31'd0, tmo}, 0);
        check("sat_cycle", {28'd0, s_cyc}, 15);
        check("sat_instr", {28'd0, s_icnt}, 15);
        check("sat_halted", {31'd0, s_hlt}, 0);
`ifdef PIPE_MON_TIMEOUT_EN
        check("to_halted", {31'd0, t_hlt}, 1);
        check("to_timeout", {31'd0, t_tmo}, 1);
        check("to_len", {29'd0, t_len}, 0);
        check("to_cycle", t_cyc, 20);
        check("to_hpc", t_hpc, 32'h14C);
`endif

        // Asynchronous reset mid-count
        for (int i = 0; i < 3; i++) step(32'h300 + 32'(4 * i), 32'h33, 1'b0);
        check("pre_areset_cycle", cyc, 23);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_cycle", cyc, 0);
        check("areset_instr", icnt, 0);
        check("areset_sat_cycle", {28'd0, s_cyc}, 0);
        #10;
        reset_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_monitor.md
# pipeline_monitor

Synthesizable run monitor on the debug outputs of the 5-stage RISC-V `datapath`: it consumes `pc_current`, `instruction_current` and `stall_debug`. It counts cycles and retired instructions, and detects the halt loop a finished program spins in (period 1 to 4 instructions). It freezes its counters and raises `halted`, so benches and the SoC status register read a stable result without software loop detection.

## Interface
- `CNT_W`, 32: width of both counters.
- `THR1`/`THR2`/`THR3`/`THR4`, 3/4/6/8: consecutive matches needed to declare a loop of period 1/2/3/4.
- `NOP_INSTR`, 32'h00000013: encoding excluded from the instruction count.
- `TIMEOUT_CYCLES`, 2000: cycle limit; used only with `PIPE_MON_TIMEOUT_EN`.

- `clock` in 1: rising-edge clock, shared with `datapath`.
- `reset_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous; returns all state to its reset value.
- `pc` in 32: `pc_current` from the datapath.
- `instr` in 32: `instruction_current` from the datapath.
- `stall` in 1: `stall_debug` from the datapath.
- `cycle_count` out CNT_W: running cycles since reset/clear.
- `instr_count` out CNT_W: counted instructions.
- `halted` out 1: sticky; a loop or timeout was detected.
- `loop_len` out 3: detected period 1..4; 0 means none or timeout.
- `halt_pc` out 32: `pc` sampled at the halting edge.
- `timeout` out 1: halt caused by the timeout.

## Operation
- **States:** RUN and HALT. Reset or `clear` leads to RUN. RUN goes to HALT on detection. HALT is left only through `clear` or `reset_n`.
- **RUN, every edge:**
  - `cycle_count` increments.
  - `instr_count` increments if `!stall && instr != NOP_INSTR`.
  - Both counters saturate at all-ones.
- **History:** 4-entry PC history plus the previous `instr`, with a fill counter `hv` (0..4).
  - Updated only on edges with `stall`=0.
  - On stall edges, history, `hv` and the match counters all hold. A stall bubble therefore never counts as a loop.
- **Match counters,** k = 1..4, on each non-stall RUN edge:
  - Match for k≥2: `hv`≥k and `pc` equals the PC sampled k non-stall edges earlier.
  - Match for k=1: additionally requires `instr` equal to the previous `instr`.
  - A match increments `mc_k`; a miss sets `mc_k` to 0.
- **Detection:** on the edge where any `mc_k` reaches `THRk`:
  - `halted`<=1, `loop_len`<=k, `halt_pc`<=`pc`.
  - If several k reach threshold on the same edge, the smallest k wins.
- **HALT:** all outputs and state hold. Inputs are ignored except `clear`.
- **`clear`:** has priority over every other event on the same edge, including detection.

## Timing
- **Reset values:** every output is 0. History, `hv` and `mc_k` are 0. The reset is asynchronous: it takes effect mid-operation immediately, without waiting for a clock edge.
- **Registered outputs:**
  - `halted`, `loop_len`, `halt_pc` and `timeout` are visible the cycle after the detecting edge.
  - The detecting edge itself is included in `cycle_count` and `instr_count`.
- **Latency from a steady pattern** (no stalls), counted from the first edge of the pattern:
  - Period 1: 4th edge.
  - Period 2: 6th edge.
  - Period 3: 9th edge.
  - Period 4: 12th edge.
- No handshake: the monitor is purely observational and never back-pressures the datapath.

## Configuration
- **`PIPE_MON_TIMEOUT_EN` defined:**
  - When `cycle_count` becomes equal to `TIMEOUT_CYCLES` on a RUN edge, the block halts with `timeout`=1, `loop_len`=0 and `halt_pc`=`pc`.
  - If a loop is detected on the same edge, the loop wins and `timeout` stays 0.
- **Undefined:** no timeout logic; `timeout` is tied to 0.

## Test plan
- **Period-1 loop:** release `reset_n`, then hold `pc`=0x28, `instr`=0x0000006F, `stall`=0. Expect `halted`=1 after the 4th edge, `loop_len`=1, `halt_pc`=0x28, `cycle_count`=4, `instr_count`=4.
- **Period-2 loop:** alternate `pc` 0x40/0x44, `instr` 0x13/0x0000006F. Expect halt after the 6th edge, `loop_len`=2, `halt_pc`=0x44, `instr_count`=3.
- **Stall immunity:**
  - Stimulus: sequential PCs 0x0,0x4,..., then `stall`=1 with `pc`=0x10 fixed for 10 cycles.
  - Expect: `halted` stays 0, `cycle_count` advances by 10, `instr_count` is unchanged during the stall.
  - Then run a period-4 loop 0x20..0x2C: expect `loop_len`=4 after its 12th non-stall edge.
- **Clear and async reset:**
  - Pulse `clear` while halted: all outputs are 0 the next cycle, and a new loop is detected again.
  - Assert `reset_n`=0 mid-count: outputs go to 0 without waiting for a clock edge.
- **Timeout (`PIPE_MON_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=20):** feed non-repeating PCs. Expect `halted`=1, `timeout`=1, `loop_len`=0, `cycle_count`=20.
- **Saturation (`CNT_W`=4):** run 20 non-repeating cycles. Expect `cycle_count` to stick at 15 with no wrap.
